// File: rtl/data_memory_stage_pkg.sv
// Shared definitions for the data memory stage: access-size codes, FSM encoding, size helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package data_memory_stage_pkg;

  // Funct3 access size / signedness codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bytes touched by an access: 1, 2, 4 or 8 (from the low two size bits).
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [2:0] funct3);
    logic [2:0] m;
    case (funct3[1:0])
      2'b00:   m = 3'b000;
      2'b01:   m = 3'b001;
      2'b10:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_stage_load_extend.sv
// Load extender: picks the low 1/2/4/8 bytes of an 8-byte window and sign/zero-extends to 64 bits.
// Latency: combinational.
// Backpressure: none.
// Ports: win (8-byte little-endian window, byte 0 at the access address), funct3 (size/sign), data (extended result).
module data_memory_stage_load_extend
  import data_memory_stage_pkg::*;
(
  input  logic [63:0] win,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  always_comb begin
    data = win;
    case (funct3)
      LB:      data = {{56{win[7]}},  win[7:0]};
      LH:      data = {{48{win[15]}}, win[15:0]};
      LW:      data = {{32{win[31]}}, win[31:0]};
      LBU:     data = {56'b0, win[7:0]};
      LHU:     data = {48'b0, win[15:0]};
      LWU:     data = {32'b0, win[31:0]};
      default: data = win;
    endcase
  end

endmodule

// File: rtl/data_memory_stage.sv
// Memory stage: little-endian b/h/w/d loads and stores into an internal byte array, with fault detection.
// Latency: legal access completes (Done) WAIT_CYCLES+2 cycles after the request; a rejected one after 1 cycle.
// Backpressure: Stall holds the core (PC/write-back) from the request cycle until the Done cycle.
// Ports: clk, reset_n (async active-low); MemRead/MemWrite/Funct3/Address/WriteData request held while Stall;
//        ReadData (registered extended load data), Stall, Done (1-cycle pulse), Fault (valid with Done).
module data_memory_stage
  import data_memory_stage_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Fault
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     a_q;
  logic [2:0]        f3_q;
  logic [63:0]       wd_q;
  logic              wr_q;
  logic              fault_q;
  logic              access;
  logic [63:0]       win;
  logic [63:0]       load_val;

  logic [7:0] mem [DEPTH_BYTES];

  wire req = MemRead | MemWrite;

  // Full 64-bit range check so high address bits can never alias into the array.
  wire illegal = (MemRead & MemWrite)
               | (Funct3 == 3'b111)
               | (MemWrite & Funct3[2])
               | (Address >= 64'(DEPTH_BYTES))
               | (|(Address[2:0] & align_mask(Funct3)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    Done      = 1'b0;
    Fault     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        Stall = req;
        if (req) state_nxt = illegal ? DONE : WAIT;
      end
      WAIT: begin
        Stall = 1'b1;
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The core advances at the end of this cycle, so any request seen here is stale.
        Done      = 1'b1;
        Fault     = fault_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      a_q      <= '0;
      f3_q     <= '0;
      wd_q     <= '0;
      wr_q     <= 1'b0;
      fault_q  <= 1'b0;
      ReadData <= '0;
    end else if (state == IDLE && req) begin
      if (illegal) begin
        // Any rejected access leaves zero on ReadData so stale data never looks like a result.
        fault_q  <= 1'b1;
        ReadData <= '0;
      end else begin
        fault_q <= 1'b0;
        a_q     <= Address[AW-1:0];
        f3_q    <= Funct3;
        wd_q    <= WriteData;
        wr_q    <= MemWrite;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end
    end else if (state == WAIT) begin
      if (cnt != '0)   cnt      <= cnt - 1'b1;
      else if (!wr_q)  ReadData <= load_val;
    end
  end

  // Array has no reset; a reset mid-access drops state to IDLE so access never fires.
  always_ff @(posedge clk) begin
    if (access && wr_q) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(size_bytes(f3_q))) mem[a_q + AW'(k)] <= wd_q[8*k +: 8];
      end
    end
  end

  // Bytes beyond the access size may wrap the index; the extender discards them.
  always_comb begin
    win = '0;
    for (int k = 0; k < 8; k++) win[8*k +: 8] = mem[a_q + AW'(k)];
  end

  data_memory_stage_load_extend u_load_extend (
    .win    (win),
    .funct3 (f3_q),
    .data   (load_val)
  );

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- Memory stage directly downstream of the 64-bit ALU. Takes the ALU `Result` as a byte address, plus store data and access size from the decoded instruction.
- Performs little-endian byte/half/word/double loads and stores against an internal byte-addressed array with a configurable fixed latency.
- Drives `Stall` to freeze the PC and register-file write-back until the access completes. Also flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_BYTES, 512, size of the data array in bytes; must be a power of two and at least 8.
- WAIT_CYCLES, 2, extra wait cycles per access; 0 is legal.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- MemRead  input  1  load request, level, held by the core while `Stall` is high
- MemWrite  input  1  store request, level, held by the core while `Stall` is high
- Funct3  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- Address  input  64  byte address (ALU Result)
- WriteData  input  64  store data, low-order bytes used
- ReadData  output  64  extended load data, registered
- Stall  output  1  core must hold PC/instruction this cycle
- Done  output  1  one-cycle completion pulse
- Fault  output  1  access rejected; valid only with Done

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, ReadData=0, Done=0, Fault=0.
  - Array contents are not cleared.
  - A reset mid-access abandons the access; a pending store is not written.
- States: IDLE, WAIT, DONE. Encoding lives in the package.
- IDLE:
  - req = MemRead|MemWrite.
  - If req is legal: latch Address, Funct3, WriteData and the read/write flag; load counter with WAIT_CYCLES; go to WAIT.
  - If req is illegal: set Fault; go to DONE with no array access.
- Legality — any of the following makes the request illegal:
  - MemRead and MemWrite both 1.
  - Funct3=111.
  - Store with Funct3[2]=1.
  - Address >= DEPTH_BYTES; the full 64-bit compare applies, with no wrap.
  - Misalignment: half with Address[0]≠0, word with Address[1:0]≠0, double with Address[2:0]≠0.
- WAIT:
  - If counter≠0, decrement.
  - If counter=0, perform the access at this edge and go to DONE.
  - Store: write 1/2/4/8 bytes of WriteData; byte k of the data goes to address A+k.
  - Load: ReadData <= extended value; sign-extend for 000/001/010, zero-extend for 100/101/110.
- DONE:
  - Done=1; Fault holds the latched value.
  - ReadData holds its value until the next completed load. Faulted loads set ReadData=0.
  - Next state is IDLE unconditionally. Requests sampled in DONE are ignored, because the core advances its PC at this edge.
- Stall = (IDLE & req) | WAIT; combinational, so the PC never advances on the request cycle. Stall=0 in DONE.
- Latency for a legal request in cycle 0:
  - WAIT occupies cycles 1..WAIT_CYCLES+1.
  - Done in cycle WAIT_CYCLES+2; 4 with the default.
  - Illegal request: Done in cycle 1.
- Store-then-load to the same bytes returns the new data; the store commits before the load can start.
- Inputs are ignored outside IDLE; latched copies are used.

Decomposition:
- Shared package:
  - Funct3 size constants (LB, LH, LW, LD, LBU, LHU, LWU).
  - State encoding (IDLE, WAIT, DONE).
  - Size-to-byte-count and alignment-mask helper functions.
- Sub-module load_extend: combinational. Takes an 8-byte window and Funct3 and returns the 64-bit sign- or zero-extended value. Verified standalone.

Test Plan:
- Reset: reset_n=0 mid-WAIT of a store `sd` of 0x1122334455667788 to 0x10 → state IDLE, Stall=0, ReadData=0. A later `ld` of 0x10 does not return 0x1122334455667788.
- Store/load round trip: `sd` 0x8877665544332211 to 0x20 → Stall high cycles 0–3, Done in cycle 4. Then:
  - `ld` 0x20 → 0x8877665544332211.
  - `lbu` 0x27 → 0x0000000000000088.
  - `lb` 0x27 → 0xFFFFFFFFFFFFFF88.
- Word/half extension: `sw` 0x80000001 to 0x40 → `lw` 0x40 = 0xFFFFFFFF80000001; `lwu` 0x40 = 0x0000000080000001; `lhu` 0x42 = 0x0000000000008000.
- Partial store: `sd` all-ones to 0x48, then `sb` 0x00 to 0x4A → `ld` 0x48 = 0xFFFFFFFFFF00FFFF.
- Faults (each: Done in cycle 1, Fault=1, ReadData=0, array unchanged):
  - `lw` at 0x42 (misaligned).
  - `ld` at 0x200 (out of range).
  - MemRead=MemWrite=1.
  - Store with Funct3=100.
- Latency sweep: WAIT_CYCLES=0 → Done in cycle 2; WAIT_CYCLES=5 → Done in cycle 7. Requests held through DONE produce exactly one access per request.
